mcu_mem_sched: RTL and testbench
================================

// Module: mcu_mem_sched
// PURPOSE
// - Schedules single-byte accesses to the shared cart memory port for two requesters:
//   - the MCU command path: read/write request pulses from the SPI command decoder;
//   - the SD DMA engine: byte write pulses.
// - Issues an access only while the SNES-side bus window (mem_free) is open.
// - Returns a one-cycle ready pulse per completed access.
// - Enforces fixed priority with a DMA starvation guard. Sits between the command decoder/DMA and the memory mux.
// PARAMETERS
// - ACCESS_CYCLES   2     cycles mem_rd/mem_we are held per access (1..15)
// - STARVE_LIMIT    4     consecutive DMA grants allowed while an MCU request is pending (1..15)
// - TIMEOUT_CYCLES  1024  IDLE wait limit with pending work and mem_free low (MEM_SCHED_TIMEOUT_EN only)
// PORTS
// - clk          in   1   system clock; all logic on posedge
// - rst_n        in   1   asynchronous active-low reset
// - mcu_rrq      in   1   MCU read request pulse (1 cycle)
// - mcu_wrq      in   1   MCU write request pulse (1 cycle)
// - mcu_addr     in   24  MCU address; held stable until mcu_rq_rdy
// - mcu_wdata    in   8   MCU write data; held stable until mcu_rq_rdy
// - mcu_rq_rdy   out  1   pulse: MCU access complete
// - mcu_rdata    out  8   read data; valid from the mcu_rq_rdy cycle until the next MCU read completes
// - dma_wrq      in   1   DMA write request pulse
// - dma_addr     in   24  DMA address; held stable until dma_rdy
// - dma_wdata    in   8   DMA write data; held stable until dma_rdy
// - dma_rdy      out  1   pulse: DMA write complete
// - mem_free     in   1   1 = memory port may be used this cycle
// - mem_addr     out  24  memory address
// - mem_wdata    out  8   memory write data
// - mem_rdata    in   8   memory read data
// - mem_rd       out  1   read strobe
// - mem_we       out  1   write strobe
// - cur_src      out  2   00 none, 01 MCU read, 10 MCU write, 11 DMA
// - timeout_err  out  1   pulse: pending request dropped on timeout
// BEHAVIOUR
// - Reset: state IDLE; pending bits, streak counter and timeout counter = 0; all outputs = 0.
//   - rst_n low mid-access aborts the access at once; no rdy pulse is issued.
// - Request latching: a request pulse sets its pending bit (prd/pwr/pdma) on the same edge.
//   - A pulse while the same bit is already pending, or while that source is in service, is ignored.
// - Arbitration in IDLE, using registered pending bits, only when mem_free=1:
//   - Priority: DMA > MCU write > MCU read.
//   - If streak==STARVE_LIMIT and (pwr|prd): grant the highest pending MCU source instead; streak <= 0.
//   - Any DMA grant while (pwr|prd): streak++. Any MCU grant: streak <= 0.
// - FSM IDLE -> ACCESS -> DONE -> IDLE:
//   - IDLE->ACCESS on grant: latch the winner's addr/wdata into mem_addr/mem_wdata;
//     set cur_src; cnt <= ACCESS_CYCLES-1.
//   - ACCESS: mem_rd (MCU read) or mem_we (write) held high; cnt-- each cycle.
//     - On cnt==0: capture mem_rdata into mcu_rdata for reads; go to DONE.
//   - ACCESS abort: mem_free=0 in any ACCESS cycle drops strobes next edge and returns to IDLE.
//     - The pending bit is kept; the access is retried and streak is not changed again.
//   - DONE: strobes low; one-cycle rdy pulse to the winner; clear its pending bit;
//     cur_src <= 00; go to IDLE.
//     - A new request from the same source is accepted from the DONE cycle onward.
// - Latency: pulse at cycle N with mem_free=1 -> strobes N+2..N+1+ACCESS_CYCLES
//   -> rdy at N+2+ACCESS_CYCLES (N+4 with defaults).
// - Simultaneous rrq and wrq pulses: both latched; write served first.
// - Counters saturate; streak never exceeds STARVE_LIMIT.
// CONFIGURATION
// - MEM_SCHED_TIMEOUT_EN defined:
//   - tcnt counts IDLE cycles with any pending bit set and mem_free=0; it resets on any grant.
//   - At TIMEOUT_CYCLES: the highest-priority pending bit is cleared and timeout_err pulses 1 cycle.
//   - No rdy pulse is issued; if the dropped request is an MCU read, mcu_rdata <= 8'hFF.
// - MEM_SCHED_TIMEOUT_EN undefined: waits indefinitely; timeout_err tied 0; TIMEOUT_CYCLES unused.
// TESTING
// - Read: mem_free=1, mem_rdata=8'h5A, mcu_rrq at cycle 10 -> mem_rd high cycles 12-13,
//   mcu_rq_rdy at 14, mcu_rdata=8'h5A.
// - Simultaneous: mcu_wrq+dma_wrq same cycle -> DMA access first (dma_rdy),
//   then MCU write (mcu_rq_rdy); 2 back-to-back accesses.
// - Starvation: dma_wrq re-pulsed on every dma_rdy, mcu_rrq pending -> MCU read granted
//   after exactly 4 DMA writes.
// - Window loss: mem_free falls in the first ACCESS cycle of a DMA write ->
//   mem_we drops, retry once mem_free=1, single dma_rdy.
// - Reset: rst_n low mid-ACCESS -> all outputs 0 asynchronously; no rdy after release.
// - Timeout (macro on, TIMEOUT_CYCLES=16): mcu_rrq, mem_free=0 ->
//   timeout_err after 16 IDLE cycles, mcu_rdata=8'hFF, no mcu_rq_rdy.

Source files
------------

// File: rtl/mcu_mem_sched.sv
// rtl/mcu_mem_sched.sv - byte access scheduler for the shared cart memory port (MCU + SD DMA)
//
// Purpose:
//   Arbitrates single-byte accesses from the MCU command path (read/write) and
//   the SD DMA engine (write) onto one memory port. Accesses are issued only
//   while mem_free is high. The fixed priority is DMA > MCU write > MCU read.
//   A streak counter lets a waiting MCU request through after STARVE_LIMIT
//   DMA grants. Each completed access returns a one-cycle rdy pulse.
//
// Optional feature:
//   MEM_SCHED_TIMEOUT_EN - drops the highest-priority pending request after
//   TIMEOUT_CYCLES idle cycles with mem_free low and pulses timeout_err.
//   When undefined, requests wait indefinitely and timeout_err is tied 0.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mcu_rrq, mcu_wrq        MCU read / write request pulses
//   mcu_addr, mcu_wdata     MCU address / write data, held until mcu_rq_rdy
//   mcu_rq_rdy, mcu_rdata   MCU completion pulse / last read data
//   dma_wrq                 DMA write request pulse
//   dma_addr, dma_wdata     DMA address / write data, held until dma_rdy
//   dma_rdy                 DMA completion pulse
//   mem_free                memory port usable this cycle
//   mem_addr, mem_wdata     memory address / write data
//   mem_rdata               memory read data
//   mem_rd, mem_we          memory read / write strobes
//   cur_src                 00 none, 01 MCU read, 10 MCU write, 11 DMA
//   timeout_err             pulse: pending request dropped on timeout
module mcu_mem_sched #(
    parameter int ACCESS_CYCLES  = 2,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mcu_rrq,
    input  logic        mcu_wrq,
    input  logic [23:0] mcu_addr,
    input  logic [7:0]  mcu_wdata,
    output logic        mcu_rq_rdy,
    output logic [7:0]  mcu_rdata,
    input  logic        dma_wrq,
    input  logic [23:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_rdy,
    input  logic        mem_free,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_rd,
    output logic        mem_we,
    output logic [1:0]  cur_src,
    output logic        timeout_err
);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_RD   = 2'b01;
    localparam logic [1:0] SRC_WR   = 2'b10;
    localparam logic [1:0] SRC_DMA  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        prd;
    logic        pwr;
    logic        pdma;
    logic [3:0]  cnt;
    logic [3:0]  streak;
    logic [1:0]  retry_src;
    logic        grant;
    logic [1:0]  grant_src;
    logic        starve;

    // Arbitration and next state. Uses only registered pending bits, so a
    // pulse is never granted on the edge that latches it.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_src = SRC_NONE;
        starve    = (streak == 4'(STARVE_LIMIT)) && (pwr || prd);
        case (state)
            S_IDLE: begin
                if (mem_free && (pdma || pwr || prd)) begin
                    grant     = 1'b1;
                    state_nxt = S_ACCESS;
                    if (pdma && !starve) begin
                        grant_src = SRC_DMA;
                    end else if (pwr) begin
                        grant_src = SRC_WR;
                    end else begin
                        grant_src = SRC_RD;
                    end
                end
            end
            S_ACCESS: begin
                if (!mem_free) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef MEM_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
`else
    // Timeout feature absent: never flag a drop.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prd        <= 1'b0;
            pwr        <= 1'b0;
            pdma       <= 1'b0;
            cnt        <= 4'd0;
            streak     <= 4'd0;
            retry_src  <= SRC_NONE;
            mem_addr   <= 24'd0;
            mem_wdata  <= 8'd0;
            mem_rd     <= 1'b0;
            mem_we     <= 1'b0;
            cur_src    <= SRC_NONE;
            mcu_rq_rdy <= 1'b0;
            dma_rdy    <= 1'b0;
            mcu_rdata  <= 8'd0;
`ifdef MEM_SCHED_TIMEOUT_EN
            tcnt        <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            mcu_rq_rdy <= 1'b0;
            dma_rdy    <= 1'b0;
`ifdef MEM_SCHED_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            // A pending bit stays set through service, so a repeat pulse is
            // ignored until the bit clears on entry to DONE.
            if (mcu_rrq && !prd) prd  <= 1'b1;
            if (mcu_wrq && !pwr) pwr  <= 1'b1;
            if (dma_wrq && !pdma) pdma <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (grant) begin
                        cur_src <= grant_src;
                        cnt     <= 4'(ACCESS_CYCLES - 1);
                        mem_rd  <= (grant_src == SRC_RD);
                        mem_we  <= (grant_src != SRC_RD);
                        if (grant_src == SRC_DMA) begin
                            mem_addr  <= dma_addr;
                            mem_wdata <= dma_wdata;
                        end else begin
                            mem_addr  <= mcu_addr;
                            mem_wdata <= mcu_wdata;
                        end
                        // A retry of an aborted access was already counted.
                        if (grant_src != retry_src) begin
                            if (grant_src != SRC_DMA) begin
                                streak <= 4'd0;
                            end else if ((pwr || prd) && (streak < 4'(STARVE_LIMIT))) begin
                                streak <= streak + 4'd1;
                            end
                        end
                        retry_src <= SRC_NONE;
`ifdef MEM_SCHED_TIMEOUT_EN
                        tcnt <= '0;
                    end else if ((pdma || pwr || prd) && !mem_free) begin
                        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            tcnt        <= '0;
                            timeout_err <= 1'b1;
                            if (pdma) begin
                                pdma <= 1'b0;
                            end else if (pwr) begin
                                pwr <= 1'b0;
                            end else begin
                                prd       <= 1'b0;
                                mcu_rdata <= 8'hFF;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
`endif
                    end
                end
                S_ACCESS: begin
                    if (!mem_free) begin
                        // Window lost: abandon, keep pending bit for retry.
                        mem_rd    <= 1'b0;
                        mem_we    <= 1'b0;
                        retry_src <= cur_src;
                        cur_src   <= SRC_NONE;
                    end else if (cnt == 4'd0) begin
                        mem_rd <= 1'b0;
                        mem_we <= 1'b0;
                        case (cur_src)
                            SRC_DMA: begin
                                pdma    <= 1'b0;
                                dma_rdy <= 1'b1;
                            end
                            SRC_WR: begin
                                pwr        <= 1'b0;
                                mcu_rq_rdy <= 1'b1;
                            end
                            SRC_RD: begin
                                prd        <= 1'b0;
                                mcu_rq_rdy <= 1'b1;
                                mcu_rdata  <= mem_rdata;
                            end
                            default: begin
                            end
                        endcase
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    cur_src <= SRC_NONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_mem_sched.sv
// tb/tb_mcu_mem_sched.sv - scoreboard bench for mcu_mem_sched
module tb_mcu_mem_sched;

    localparam int AC = 2;
    localparam int SL = 4;
    localparam int TC = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mcu_rrq, mcu_wrq, dma_wrq, mem_free;
    logic [23:0] mcu_addr, dma_addr;
    logic [7:0]  mcu_wdata, dma_wdata, mem_rdata;
    logic        mcu_rq_rdy, dma_rdy, mem_rd, mem_we, timeout_err;
    logic [7:0]  mcu_rdata, mem_wdata;
    logic [23:0] mem_addr;
    logic [1:0]  cur_src;

    mcu_mem_sched #(
        .ACCESS_CYCLES(AC),
        .STARVE_LIMIT(SL),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mcu_rrq(mcu_rrq), .mcu_wrq(mcu_wrq), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
        .mcu_rq_rdy(mcu_rq_rdy), .mcu_rdata(mcu_rdata),
        .dma_wrq(dma_wrq), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdy(dma_rdy),
        .mem_free(mem_free), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rd(mem_rd), .mem_we(mem_we), .cur_src(cur_src), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [23:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t mcu_q[$];
    exp_t dma_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mcu_rdy_cnt = 0;
    int dma_rdy_cnt = 0;
    int last_mcu_cyc = 0;
    int last_dma_cyc = 0;
    logic [23:0] seen_addr = '0;
    logic [7:0]  seen_wdata = '0;
    exp_t mon_e;

    always @(posedge clk) cyc++;

    // Scoreboard: pop the oldest expectation of a source on its rdy pulse.
    always @(negedge clk) begin
        if (mem_rd || mem_we) begin
            seen_addr  = mem_addr;
            seen_wdata = mem_wdata;
        end
        if (dma_rdy) begin
            dma_rdy_cnt++;
            last_dma_cyc = cyc;
            total++;
            if (dma_q.size() == 0) begin
                bad++;
                $display("FAIL sb_dma_unexpected: dma_rdy at cycle %0d, nothing expected", cyc);
            end else begin
                mon_e = dma_q.pop_front();
                if (cur_src !== 2'b11 || seen_addr !== mon_e.addr || seen_wdata !== mon_e.data) begin
                    bad++;
                    $display("FAIL sb_dma: got src=%b addr=%h data=%h, want src=11 addr=%h data=%h",
                             cur_src, seen_addr, seen_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
        if (mcu_rq_rdy) begin
            mcu_rdy_cnt++;
            last_mcu_cyc = cyc;
            total++;
            if (mcu_q.size() == 0) begin
                bad++;
                $display("FAIL sb_mcu_unexpected: mcu_rq_rdy at cycle %0d, nothing expected", cyc);
            end else begin
                mon_e = mcu_q.pop_front();
                if (cur_src !== mon_e.src || seen_addr !== mon_e.addr ||
                    ((mon_e.src == 2'b01) ? (mcu_rdata !== mon_e.data) : (seen_wdata !== mon_e.data))) begin
                    bad++;
                    $display("FAIL sb_mcu: got src=%b addr=%h wdata=%h rdata=%h, want src=%b addr=%h data=%h",
                             cur_src, seen_addr, seen_wdata, mcu_rdata, mon_e.src, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (mcu_q.size() == 0 && dma_q.size() == 0) break;
        end
        total++;
        if (mcu_q.size() != 0 || dma_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: mcu_q=%0d dma_q=%0d left, want 0 0", name, mcu_q.size(), dma_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mcu_rrq = 0; mcu_wrq = 0; dma_wrq = 0; mem_free = 1;
        mcu_addr = '0; dma_addr = '0; mcu_wdata = '0; dma_wdata = '0; mem_rdata = '0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        total++;
        if ({mem_rd, mem_we, mcu_rq_rdy, dma_rdy, cur_src, timeout_err} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b, want 0000000",
                     {mem_rd, mem_we, mcu_rq_rdy, dma_rdy, cur_src, timeout_err});
        end
        total++;
        if (mem_addr !== 24'd0 || mem_wdata !== 8'd0 || mcu_rdata !== 8'd0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, want 0", mem_addr, mem_wdata, mcu_rdata);
        end
    endtask

    task automatic test_read_latency();
        logic rd_h [6];
        logic rdy_h[6];
        idle_cycles(2);
        mem_rdata = 8'h5A;
        mcu_addr  = 24'h01_0203;
        mcu_rrq   = 1;
        mcu_q.push_back('{2'b01, 24'h01_0203, 8'h5A});
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rd_h[k]  = mem_rd;
            rdy_h[k] = mcu_rq_rdy;
            @(posedge clk);
            #1 mcu_rrq = 0;
        end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (rd_h[k] !== ((k >= 2) && (k <= 1 + AC)) || rdy_h[k] !== (k == 2 + AC)) begin
                bad++;
                $display("FAIL read_latency_n%0d: got rd=%b rdy=%b, want rd=%b rdy=%b", k, rd_h[k], rdy_h[k],
                         (k >= 2) && (k <= 1 + AC), k == 2 + AC);
            end
        end
        total++;
        if (mcu_rdata !== 8'h5A) begin
            bad++;
            $display("FAIL read_hold: got rdata=%h, want 5a", mcu_rdata);
        end
    endtask

    task automatic test_simultaneous();
        int m0, d0;
        idle_cycles(2);
        m0 = mcu_rdy_cnt; d0 = dma_rdy_cnt;
        mcu_addr = 24'h00_1234; mcu_wdata = 8'hC3;
        dma_addr = 24'hAB_0001; dma_wdata = 8'h7E;
        mcu_wrq = 1; dma_wrq = 1;
        mcu_q.push_back('{2'b10, 24'h00_1234, 8'hC3});
        dma_q.push_back('{2'b11, 24'hAB_0001, 8'h7E});
        @(posedge clk);
        #1 mcu_wrq = 0; dma_wrq = 0;
        wait_drain("simul_dma_wr", 30);
        total++;
        if (dma_rdy_cnt != d0 + 1 || mcu_rdy_cnt != m0 + 1 || last_mcu_cyc - last_dma_cyc != AC + 2) begin
            bad++;
            $display("FAIL simul_order: got dma=%0d mcu=%0d gap=%0d, want 1 1 gap=%0d",
                     dma_rdy_cnt - d0, mcu_rdy_cnt - m0, last_mcu_cyc - last_dma_cyc, AC + 2);
        end
        mcu_addr = 24'h00_2000; mcu_wdata = 8'h11; mem_rdata = 8'hE7;
        mcu_rrq = 1; mcu_wrq = 1;
        mcu_q.push_back('{2'b10, 24'h00_2000, 8'h11});
        mcu_q.push_back('{2'b01, 24'h00_2000, 8'hE7});
        @(posedge clk);
        #1 mcu_rrq = 0; mcu_wrq = 0;
        wait_drain("simul_rd_wr", 40);
    endtask

    task automatic test_starvation();
        int dmas_before;
        bit mcu_done;
        idle_cycles(2);
        dmas_before = 0; mcu_done = 0;
        mem_rdata = 8'h99;
        mcu_addr = 24'h00_3000;
        dma_addr = 24'h10_0000; dma_wdata = 8'h42;
        mcu_rrq = 1; dma_wrq = 1;
        mcu_q.push_back('{2'b01, 24'h00_3000, 8'h99});
        dma_q.push_back('{2'b11, 24'h10_0000, 8'h42});
        @(posedge clk);
        #1 mcu_rrq = 0; dma_wrq = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mcu_rq_rdy) mcu_done = 1;
            if (dma_rdy && !mcu_done) begin
                dmas_before++;
                dma_wrq = 1;
                dma_q.push_back('{2'b11, 24'h10_0000, 8'h42});
            end
            @(posedge clk);
            #1 dma_wrq = 0;
            if (mcu_done && dma_q.size() == 0) break;
        end
        total++;
        if (!mcu_done || dmas_before != SL) begin
            bad++;
            $display("FAIL starvation: got mcu_done=%0d dma_before=%0d, want 1 %0d", mcu_done, dmas_before, SL);
        end
        wait_drain("starvation", 20);
    endtask

    task automatic test_window_loss();
        int d0;
        bit seen;
        idle_cycles(2);
        d0 = dma_rdy_cnt; seen = 0;
        dma_addr = 24'h20_0055; dma_wdata = 8'h5C;
        dma_wrq = 1;
        dma_q.push_back('{2'b11, 24'h20_0055, 8'h5C});
        @(posedge clk);
        #1 dma_wrq = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_we) begin
                seen = 1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL window_start: got mem_we=0, want 1 within 10 cycles");
        end
        mem_free = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (mem_we !== 1'b0 || dma_rdy !== 1'b0) begin
                bad++;
                $display("FAIL window_drop%0d: got we=%b rdy=%b, want 0 0", i, mem_we, dma_rdy);
            end
        end
        mem_free = 1;
        wait_drain("window_retry", 20);
        idle_cycles(8);
        total++;
        if (dma_rdy_cnt != d0 + 1) begin
            bad++;
            $display("FAIL window_single_rdy: got %0d pulses, want 1", dma_rdy_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int m0;
        bit seen, rd_after;
        idle_cycles(2);
        m0 = mcu_rdy_cnt; seen = 0; rd_after = 0;
        mcu_addr = 24'h00_4000; mem_rdata = 8'h77;
        mcu_rrq = 1;
        @(posedge clk);
        #1 mcu_rrq = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_rd) begin
                seen = 1;
                break;
            end
        end
        rst_n = 0;
        #1;
        total++;
        if (!seen || {mem_rd, mem_we, mcu_rq_rdy, dma_rdy, cur_src} !== 6'b0 ||
            mem_addr !== 24'd0 || mcu_rdata !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid: got seen=%0d ctrl=%b addr=%h rdata=%h, want 1 0 0 0", seen,
                     {mem_rd, mem_we, mcu_rq_rdy, dma_rdy, cur_src}, mem_addr, mcu_rdata);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_rd) rd_after = 1;
        end
        total++;
        if (mcu_rdy_cnt != m0 || rd_after) begin
            bad++;
            $display("FAIL reset_no_rdy: got rdy=%0d rd=%0d, want 0 0", mcu_rdy_cnt - m0, rd_after);
        end
    endtask

    task automatic test_timeout();
        int m0;
        int first_k;
        bit rd_seen;
        idle_cycles(2);
        m0 = mcu_rdy_cnt; first_k = -1; rd_seen = 0;
        mem_free = 0;
        mcu_addr = 24'h00_5000;
`ifdef MEM_SCHED_TIMEOUT_EN
        mcu_rrq = 1;
        for (int k = 0; k < TC + 6; k++) begin
            @(negedge clk);
            if (timeout_err && first_k < 0) first_k = k;
            @(posedge clk);
            #1 mcu_rrq = 0;
        end
        total++;
        if (first_k != TC + 1) begin
            bad++;
            $display("FAIL timeout_cycle: got pulse at n+%0d, want n+%0d", first_k, TC + 1);
        end
        total++;
        if (mcu_rdata !== 8'hFF) begin
            bad++;
            $display("FAIL timeout_rdata: got %h, want ff", mcu_rdata);
        end
        mem_free = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_rd) rd_seen = 1;
        end
        total++;
        if (rd_seen || mcu_rdy_cnt != m0) begin
            bad++;
            $display("FAIL timeout_dropped: got rd=%0d rdy=%0d, want 0 0", rd_seen, mcu_rdy_cnt - m0);
        end
`else
        mem_rdata = 8'h3D;
        mcu_rrq = 1;
        mcu_q.push_back('{2'b01, 24'h00_5000, 8'h3D});
        for (int k = 0; k < 3 * TC; k++) begin
            @(negedge clk);
            if (timeout_err && first_k < 0) first_k = k;
            if (mem_rd) rd_seen = 1;
            @(posedge clk);
            #1 mcu_rrq = 0;
        end
        total++;
        if (first_k >= 0 || rd_seen) begin
            bad++;
            $display("FAIL no_timeout_wait: got err at %0d rd=%0d, want none", first_k, rd_seen);
        end
        mem_free = 1;
        wait_drain("no_timeout_serve", 20);
`endif
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_simultaneous();
        test_starvation();
        test_window_loss();
        test_reset_mid();
        test_timeout();
        total++;
        if (mcu_q.size() != 0 || dma_q.size() != 0) begin
            bad++;
            $display("FAIL final_queues: got mcu_q=%0d dma_q=%0d, want 0 0", mcu_q.size(), dma_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
